// File: rtl/math_game_pkg.sv
// rtl/math_game_pkg.sv - op codes, default widths and expression field helpers for the math lane game
package math_game_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  localparam int DEF_LANES     = 3;
  localparam int DEF_DEPTH     = 2;
  localparam int DEF_OPW       = 4;
  localparam int DEF_ANSW      = 10;
  localparam int DEF_SCORE_W   = 7;
  localparam int DEF_LIFE_W    = 3;
  localparam int DEF_LIFE_INIT = 3;
  localparam int DEF_LIFE_MAX  = 5;
  localparam int DEF_COMBO_MAX = 15;

  // Expressions are packed {a, op, b}; callers zero-extend to 32 bits first.
  function automatic logic [15:0] expr_a(input logic [31:0] expr, input int opw);
    return 16'(expr >> (opw + 4));
  endfunction

  function automatic logic [3:0] expr_op(input logic [31:0] expr, input int opw);
    return 4'(expr >> opw);
  endfunction

  function automatic logic [15:0] expr_b(input logic [31:0] expr, input int opw);
    return 16'(expr & ((32'd1 << opw) - 32'd1));
  endfunction

endpackage

// File: rtl/expr_alu.sv
// rtl/expr_alu.sv - combinational answer for one {a, op, b} expression
module expr_alu
  import math_game_pkg::*;
#(
  parameter int OPW  = DEF_OPW,
  parameter int ANSW = DEF_ANSW
) (
  input  logic [2*OPW+3:0] expr,
  output logic [ANSW-1:0]  answer,
  output logic             op_ok
);

  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic [3:0]     op;

  assign a  = OPW'(expr_a(32'(expr), OPW));
  assign b  = OPW'(expr_b(32'(expr), OPW));
  assign op = expr_op(32'(expr), OPW);

  always_comb begin
    answer = '0;
    op_ok  = 1'b1;
    case (op)
      OP_ADD:  answer = ANSW'(a) + ANSW'(b);
      OP_SUB:  answer = ANSW'(a) - ANSW'(b);
      OP_MUL:  answer = ANSW'(a) * ANSW'(b);
      OP_DIV:  answer = (b == '0) ? '1 : ANSW'(a / b);
      default: op_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/math_lane_engine.sv
// rtl/math_lane_engine.sv - per-lane expression queues, answer matching, score/life/combo state
module math_lane_engine
  import math_game_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int OPW       = DEF_OPW,
  parameter int ANSW      = DEF_ANSW,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int LIFE_W    = DEF_LIFE_W,
  parameter int LIFE_INIT = DEF_LIFE_INIT,
  parameter int LIFE_MAX  = DEF_LIFE_MAX,
  parameter int COMBO_MAX = DEF_COMBO_MAX,
  localparam int EW       = 2*OPW + 4,
  localparam int SEL_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_i,
  input  logic [SEL_W-1:0]          spawn_lane_i,
  input  logic [EW-1:0]             spawn_expr_i,
  input  logic                      ans_valid_i,
  input  logic [ANSW-1:0]           ans_i,
  output logic [LANES*DEPTH*EW-1:0] rows_o,
  output logic [LANES*DEPTH-1:0]    row_valid_o,
  output logic [SCORE_W-1:0]        score_o,
  output logic [LIFE_W-1:0]         life_o,
  output logic [3:0]                combo_o,
  output logic                      hit_o,
  output logic                      miss_o,
  output logic                      game_over_o
);

  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic [3:0]         combo_q, combo_d;
  logic               hit_q, miss_q, game_over_q;

  logic             tick_en, ans_en;
  logic [ANSW-1:0]  spawn_ans;
  logic             spawn_op_ok;
  logic [LANES-1:0] hit_vec, miss_vec;

  // The previous cycle's hit blocks answers so a held key only scores once.
  assign tick_en = tick_i && !game_over_q;
  assign ans_en  = ans_valid_i && !hit_q && !game_over_q;

  expr_alu #(.OPW(OPW), .ANSW(ANSW)) u_alu (
    .expr   (spawn_expr_i),
    .answer (spawn_ans),
    .op_ok  (spawn_op_ok)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_after;
    logic [EW-1:0]    expr_q [DEPTH];
    logic [ANSW-1:0]  ans_q  [DEPTH];
    logic             lane_hit, lane_miss, load, seen;

    assign load = tick_en && (spawn_lane_i == SEL_W'(l)) && spawn_op_ok && (spawn_expr_i != '0);

    // Match against the oldest occupied slot before any shift this cycle.
    always_comb begin
      lane_hit    = 1'b0;
      seen        = 1'b0;
      valid_after = valid_q;
      for (int r = DEPTH - 1; r >= 0; r--) begin
        if (valid_q[r] && !seen) begin
          seen = 1'b1;
          if (ans_en && (ans_q[r] == ans_i)) begin
            lane_hit       = 1'b1;
            valid_after[r] = 1'b0;
          end
        end
      end
      lane_miss = tick_en && valid_after[DEPTH-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int r = 0; r < DEPTH; r++) begin
          expr_q[r] <= '0;
          ans_q[r]  <= '0;
        end
      end else if (tick_en) begin
        for (int r = 1; r < DEPTH; r++) begin
          valid_q[r] <= valid_after[r-1];
          expr_q[r]  <= expr_q[r-1];
          ans_q[r]   <= ans_q[r-1];
        end
        valid_q[0] <= load;
        expr_q[0]  <= load ? spawn_expr_i : '0;
        ans_q[0]   <= load ? spawn_ans : '0;
      end else begin
        valid_q <= valid_after;
      end
    end

    assign hit_vec[l]                      = lane_hit;
    assign miss_vec[l]                     = lane_miss;
    assign row_valid_o[l*DEPTH +: DEPTH]   = valid_q;

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
      assign rows_o[(l*DEPTH + r)*EW +: EW] = valid_q[r] ? expr_q[r] : '0;
    end
  end

  int   n_hit, n_miss, score_sum, life_sum;
  logic bonus;

  always_comb begin
    n_hit  = 0;
    n_miss = 0;
    for (int l = 0; l < LANES; l++) begin
      n_hit  = n_hit + (hit_vec[l] ? 1 : 0);
      n_miss = n_miss + (miss_vec[l] ? 1 : 0);
    end

    score_sum = int'(score_q) + n_hit;
    score_d   = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);

    // A miss anywhere wipes the combo even if other lanes hit this cycle.
    bonus   = 1'b0;
    combo_d = combo_q;
    if (n_miss > 0) begin
      combo_d = '0;
    end else if (n_hit > 0) begin
      if (combo_q == 4'(COMBO_MAX)) begin
        combo_d = '0;
        bonus   = (int'(life_q) < LIFE_MAX);
      end else begin
        combo_d = combo_q + 4'd1;
      end
    end

    life_sum = int'(life_q) - n_miss + (bonus ? 1 : 0);
    if (life_sum < 0) begin
      life_d = '0;
    end else if (life_sum > LIFE_MAX) begin
      life_d = LIFE_W'(LIFE_MAX);
    end else begin
      life_d = LIFE_W'(life_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q     <= '0;
      life_q      <= LIFE_W'(LIFE_INIT);
      combo_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else if (!game_over_q) begin
      score_q     <= score_d;
      life_q      <= life_d;
      combo_q     <= combo_d;
      hit_q       <= |hit_vec;
      miss_q      <= |miss_vec;
      game_over_q <= (life_d == '0);
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end
  end

  assign score_o     = score_q;
  assign life_o      = life_q;
  assign combo_o     = combo_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_math_lane_engine.sv
// tb/tb_math_lane_engine.sv - directed vector and sequence bench for math_lane_engine
module tb_math_lane_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_i;
  logic [1:0]  spawn_lane_i;
  logic [11:0] spawn_expr_i;
  logic        ans_valid_i;
  logic [9:0]  ans_i;
  logic [71:0] rows_o;
  logic [5:0]  row_valid_o;
  logic [6:0]  score_o;
  logic [2:0]  life_o;
  logic [3:0]  combo_o;
  logic        hit_o, miss_o, game_over_o;

  int checks = 0;
  int errors = 0;

  math_lane_engine dut (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (tick_i),
    .spawn_lane_i (spawn_lane_i),
    .spawn_expr_i (spawn_expr_i),
    .ans_valid_i  (ans_valid_i),
    .ans_i        (ans_i),
    .rows_o       (rows_o),
    .row_valid_o  (row_valid_o),
    .score_o      (score_o),
    .life_o       (life_o),
    .combo_o      (combo_o),
    .hit_o        (hit_o),
    .miss_o       (miss_o),
    .game_over_o  (game_over_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] expr;
    logic [9:0]  ans;
    logic        loaded;
    logic        hit;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic do_tick(input logic [1:0] lane, input logic [11:0] expr);
    tick_i       = 1'b1;
    spawn_lane_i = lane;
    spawn_expr_i = expr;
    cycle();
    tick_i       = 1'b0;
    spawn_expr_i = '0;
  endtask

  task automatic do_ans(input logic [9:0] v);
    ans_valid_i = 1'b1;
    ans_i       = v;
    cycle();
    ans_valid_i = 1'b0;
  endtask

  task automatic hit_once();
    do_tick(2'd0, 12'h3A4);
    do_ans(10'd7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{12'h3A4, 10'd7,   1'b1, 1'b1};
    vecs[1]  = '{12'h9B2, 10'd7,   1'b1, 1'b1};
    vecs[2]  = '{12'h2C3, 10'd6,   1'b1, 1'b1};
    vecs[3]  = '{12'hFCF, 10'd225, 1'b1, 1'b1};
    vecs[4]  = '{12'h8D3, 10'd2,   1'b1, 1'b1};
    vecs[5]  = '{12'h5D0, 10'h3FF, 1'b1, 1'b1};
    vecs[6]  = '{12'h2B5, 10'h3FD, 1'b1, 1'b1};
    vecs[7]  = '{12'h3A4, 10'd8,   1'b1, 1'b0};
    vecs[8]  = '{12'h3E4, 10'd0,   1'b0, 1'b0};
    vecs[9]  = '{12'h000, 10'd0,   1'b0, 1'b0};
    vecs[10] = '{12'h0A0, 10'd0,   1'b1, 1'b1};
    vecs[11] = '{12'h7D2, 10'd3,   1'b1, 1'b1};
    vecs[12] = '{12'hF9F, 10'd0,   1'b0, 1'b0};

    rst = 1'b1; tick_i = 1'b0; spawn_lane_i = '0; spawn_expr_i = '0;
    ans_valid_i = 1'b0; ans_i = '0;
    cycle();
    cycle();
    rst = 1'b0;

    check("rst_score", 32'(score_o), 0);
    check("rst_life", 32'(life_o), 3);
    check("rst_combo", 32'(combo_o), 0);
    check("rst_valid", 32'(row_valid_o), 0);
    check("rst_rows", 32'(|rows_o), 0);
    check("rst_hit", 32'(hit_o), 0);
    check("rst_miss", 32'(miss_o), 0);
    check("rst_go", 32'(game_over_o), 0);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      do_tick(2'd0, vecs[i].expr);
      check($sformatf("v%0d_loaded", i), 32'(row_valid_o[0]), 32'(vecs[i].loaded));
      check($sformatf("v%0d_row", i), 32'(rows_o[11:0]), vecs[i].loaded ? 32'(vecs[i].expr) : 0);
      do_ans(vecs[i].ans);
      check($sformatf("v%0d_hit", i), 32'(hit_o), 32'(vecs[i].hit));
      check($sformatf("v%0d_score", i), 32'(score_o), 32'(vecs[i].hit));
    end

    do_reset();
    do_tick(2'd1, 12'h3A4);
    do_tick(2'd1, 12'h3A4);
    check("lock_fill", 32'(row_valid_o), 32'h0C);
    do_ans(10'd7);
    check("lock_hit", 32'(hit_o), 1);
    check("lock_score1", 32'(score_o), 1);
    check("lock_combo1", 32'(combo_o), 1);
    check("lock_valid1", 32'(row_valid_o), 32'h04);
    do_ans(10'd7);
    check("lock_ignored_hit", 32'(hit_o), 0);
    check("lock_ignored_score", 32'(score_o), 1);
    check("lock_ignored_valid", 32'(row_valid_o), 32'h04);
    do_ans(10'd7);
    check("lock_second_score", 32'(score_o), 2);
    check("lock_second_combo", 32'(combo_o), 2);

    do_tick(2'd0, 12'h3A4);
    do_reset();
    check("midrst_valid", 32'(row_valid_o), 0);
    check("midrst_rows", 32'(|rows_o), 0);
    check("midrst_score", 32'(score_o), 0);

    do_tick(2'd2, 12'h3A4);
    do_ans(10'd7);
    check("miss_pre_combo", 32'(combo_o), 1);
    do_tick(2'd0, 12'h9B2);
    do_tick(2'd0, 12'h000);
    check("miss_not_yet", 32'(miss_o), 0);
    do_tick(2'd0, 12'h000);
    check("miss_pulse", 32'(miss_o), 1);
    check("miss_life", 32'(life_o), 2);
    check("miss_combo", 32'(combo_o), 0);
    check("miss_valid", 32'(row_valid_o), 0);
    cycle();
    check("miss_pulse_end", 32'(miss_o), 0);

    do_reset();
    do_tick(2'd0, 12'h2C3);
    do_tick(2'd2, 12'h2C3);
    check("multi_fill", 32'(row_valid_o), 32'h12);
    do_ans(10'd6);
    check("multi_valid", 32'(row_valid_o), 0);
    check("multi_score", 32'(score_o), 2);
    check("multi_combo", 32'(combo_o), 1);

    do_reset();
    do_tick(2'd0, 12'h3A4);
    do_tick(2'd0, 12'h000);
    tick_i = 1'b1; spawn_lane_i = 2'd0; spawn_expr_i = 12'h000;
    ans_valid_i = 1'b1; ans_i = 10'd7;
    cycle();
    tick_i = 1'b0; ans_valid_i = 1'b0;
    check("same_hit", 32'(hit_o), 1);
    check("same_miss", 32'(miss_o), 0);
    check("same_life", 32'(life_o), 3);
    check("same_score", 32'(score_o), 1);

    do_reset();
    repeat (15) hit_once();
    check("wrap_pre_combo", 32'(combo_o), 15);
    check("wrap_pre_life", 32'(life_o), 3);
    hit_once();
    check("wrap_combo", 32'(combo_o), 0);
    check("wrap_life4", 32'(life_o), 4);
    repeat (16) hit_once();
    check("wrap_life5", 32'(life_o), 5);
    repeat (15) hit_once();
    check("cap_pre_combo", 32'(combo_o), 15);
    hit_once();
    check("cap_combo", 32'(combo_o), 0);
    check("cap_life", 32'(life_o), 5);
    check("cap_score", 32'(score_o), 48);
    repeat (79) hit_once();
    check("sat_score_max", 32'(score_o), 127);
    hit_once();
    check("sat_score_hold", 32'(score_o), 127);

    do_reset();
    do_tick(2'd0, 12'h9B2);
    do_tick(2'd0, 12'h9B2);
    do_tick(2'd0, 12'h9B2);
    check("go_life2", 32'(life_o), 2);
    do_tick(2'd0, 12'h000);
    check("go_life1", 32'(life_o), 1);
    check("go_not_yet", 32'(game_over_o), 0);
    do_tick(2'd0, 12'h000);
    check("go_life0", 32'(life_o), 0);
    check("go_flag", 32'(game_over_o), 1);
    do_tick(2'd1, 12'h3A4);
    check("go_frozen_valid", 32'(row_valid_o), 0);
    do_ans(10'd7);
    check("go_frozen_score", 32'(score_o), 0);
    check("go_frozen_hit", 32'(hit_o), 0);
    check("go_sticky", 32'(game_over_o), 1);
    do_reset();
    check("go_rst_flag", 32'(game_over_o), 0);
    check("go_rst_life", 32'(life_o), 3);
    check("go_rst_combo", 32'(combo_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/math_lane_engine.md
Name: math_lane_engine

Overview:
- Parametrised game core for the arithmetic-falling-expression game. It generalises the fixed 3-lane × 2-row scorer to LANES lanes × DEPTH rows.
- Holds the per-lane expression queues and computes each answer at spawn time.
- Matches keypad answers against the oldest expression in each lane.
- Maintains score, life, combo and game-over state.
- Sits between the expression generator (spawn side), the keypad decoder (answer side) and the LCD/LED display blocks (read side).

Parameters:
- LANES, 3, number of lanes (1..8)
- DEPTH, 2, rows per lane; row 0 is the top (newest), row DEPTH-1 is the bottom (oldest)
- OPW, 4, operand width
- ANSW, 10, answer width; must be ≥ 2*OPW
- SCORE_W, 7, score width
- LIFE_W, 3, life counter width
- LIFE_INIT, 3, life after reset
- LIFE_MAX, 5, life ceiling for combo bonus
- COMBO_MAX, 15, combo value at which the next hit wraps combo and grants a bonus life

Ports:
- clk  in  1  system clock (game tick domain)
- rst  in  1  synchronous, active-high reset
- tick_i  in  1  one-cycle pulse: shift all lanes down one row and spawn
- spawn_lane_i  in  $clog2(LANES)  lane for the new expression, sampled with tick_i
- spawn_expr_i  in  2*OPW+4  {a, op, b}; op codes: A=add, B=sub, C=mul, D=div
- ans_valid_i  in  1  one-cycle pulse: keypad answer ready
- ans_i  in  ANSW  entered answer
- rows_o  out  LANES*DEPTH*(2*OPW+4)  row expressions, lane-major, row-minor; 0 where the slot is empty
- row_valid_o  out  LANES*DEPTH  slot occupied flags
- score_o  out  SCORE_W  score
- life_o  out  LIFE_W  remaining life
- combo_o  out  4  combo count (drives the LED bar)
- hit_o  out  1  registered pulse: at least one lane cleared
- miss_o  out  1  registered pulse: at least one expression fell out
- game_over_o  out  1  sticky; life reached 0

Behaviour:
- Reset (rst high at a clk edge):
  - all slots invalid and rows zero
  - score 0, life LIFE_INIT, combo 0
  - hit_o, miss_o and game_over_o all 0
  - reset mid-operation discards all queue state in that cycle
- Spawn: on tick_i, an expression with an op outside A..D is dropped (no slot loaded). A zero expression is treated as empty.
- Answer at spawn: expr_alu computes the answer combinationally and stores it with the slot.
  - add and mul: zero-extended to ANSW
  - sub: two's-complement result truncated to ANSW bits
  - div: integer quotient; b=0 gives all-ones
- Tick:
  - every lane shifts down one row; row 0 receives the spawn for spawn_lane_i, else empty
  - a valid bottom row shifted out counts as one miss for that lane
- Answer match: on ans_valid_i, each lane compares ans_i with its lowest valid slot (largest row index).
  - each matching lane invalidates that slot; several lanes may clear in the same cycle
  - lanes with no valid slot never match
- Lockout: ans_valid_i is ignored in the cycle where hit_o is high, which debounces a held key.
- Same-cycle ans_valid_i and tick_i: the answer is matched against the pre-shift contents first. A cleared bottom slot is then not counted as a miss.
- Score: score += number of hits, saturating at all-ones.
- Combo, per cycle:
  - if any miss: combo = 0, and this takes priority over hits
  - else if any hit: if combo == COMBO_MAX, combo = 0 and a bonus of 1 life is granted; otherwise combo + 1
- Life: life_next = clamp(life − misses + bonus, 0, LIFE_MAX). The bonus applies only if life < LIFE_MAX.
- Game over: when life_next == 0, game_over_o is set on the next edge. While game_over_o is high, tick_i and ans_valid_i are ignored and all state freezes until rst.
- Status pulses: hit_o and miss_o are high for exactly one cycle, one cycle after the causing event.
- Latency:
  - rows_o, score_o, life_o and combo_o update on the edge that samples the event
  - there is no pipelining beyond that edge

Decomposition:
- Shared package math_game_pkg:
  - op code constants OP_ADD/SUB/MUL/DIV = 4'hA..4'hD
  - expression field-slice helpers
  - default widths
- Sub-module expr_alu (combinational, parameters OPW/ANSW): {a, op, b} → answer plus an op_ok flag.
- A generate loop over lanes instantiates the per-lane shift queue inside the top module; no separate lane module.

Test Plan:
- Reset then idle: after rst, score 0, life 3, combo 0, all row_valid_o 0, game_over_o 0.
- Spawn 3+4 (12'h3A4) in lane 1 with one tick, then ans_i=7 → slot cleared, hit_o pulses, score 1, combo 1. A repeated ans_valid_i in the next cycle is ignored.
- Spawn 9−2 (12'h9B2) in lane 0 and tick until it falls out (DEPTH ticks) → miss_o pulses, life 2, combo 0.
- Lanes 0 and 2 both hold 12'h2C3 (answer 6), ans_i=6 → both cleared, score += 2, combo += 1.
- Combo wrap: preset combo to 15 with life 3, then one more hit → combo 0, life 4. Repeat with life 5 → life stays 5.
- Game over and reset: tick out three unanswered bottom rows → life 0, game_over_o 1, further ticks and answers change nothing. Asserting rst mid-game restores all reset values.
